// File: rtl/forward_hazard_unit.sv
// EX-stage operand forwarding and load-use stall detection over a shadow EX/MEM/WB pipeline.
// Optional load-use stall and stall counter enabled by defining HAZARD_LOAD_STALL_EN.
module forward_hazard_unit #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  logic              r_ex_valid;
  logic [ADDR_W-1:0] r_ex_rs;
  logic [ADDR_W-1:0] r_ex_rt;
  logic [ADDR_W-1:0] r_ex_rd;
  logic              r_ex_reg_write;
  logic              r_ex_mem_read;
  logic              r_mem_valid;
  logic [ADDR_W-1:0] r_mem_rd;
  logic              r_mem_reg_write;
  logic              r_wb_valid;
  logic [ADDR_W-1:0] r_wb_rd;
  logic              r_wb_reg_write;

  logic              w_stall;
  logic              w_id_to_ex_valid;

  // Flush wins over stall: either one turns the ID slot into a single bubble.
  assign w_id_to_ex_valid = id_valid & ~w_stall & ~flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ex_valid      <= 1'b0;
      r_ex_rs         <= '0;
      r_ex_rt         <= '0;
      r_ex_rd         <= '0;
      r_ex_reg_write  <= 1'b0;
      r_ex_mem_read   <= 1'b0;
      r_mem_valid     <= 1'b0;
      r_mem_rd        <= '0;
      r_mem_reg_write <= 1'b0;
      r_wb_valid      <= 1'b0;
      r_wb_rd         <= '0;
      r_wb_reg_write  <= 1'b0;
    end else begin
      r_wb_valid      <= r_mem_valid;
      r_wb_rd         <= r_mem_rd;
      r_wb_reg_write  <= r_mem_reg_write;
      r_mem_valid     <= r_ex_valid;
      r_mem_rd        <= r_ex_rd;
      r_mem_reg_write <= r_ex_reg_write;
      r_ex_valid      <= w_id_to_ex_valid;
      r_ex_rs         <= id_rs;
      r_ex_rt         <= id_rt;
      r_ex_rd         <= id_rd;
      r_ex_reg_write  <= w_id_to_ex_valid & id_reg_write;
      r_ex_mem_read   <= w_id_to_ex_valid & id_mem_read;
    end
  end

  function automatic logic [1:0] fwd_sel(
    input logic              ex_valid,
    input logic [ADDR_W-1:0] src,
    input logic              mem_valid,
    input logic              mem_reg_write,
    input logic [ADDR_W-1:0] mem_rd,
    input logic              wb_valid,
    input logic              wb_reg_write,
    input logic [ADDR_W-1:0] wb_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ex_valid && src != '0) begin
      if (mem_valid && mem_reg_write && mem_rd == src)
        sel = 2'b10;
      else if (wb_valid && wb_reg_write && wb_rd == src)
        sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    forward_a = fwd_sel(r_ex_valid, r_ex_rs, r_mem_valid, r_mem_reg_write, r_mem_rd,
                        r_wb_valid, r_wb_reg_write, r_wb_rd);
    forward_b = fwd_sel(r_ex_valid, r_ex_rt, r_mem_valid, r_mem_reg_write, r_mem_rd,
                        r_wb_valid, r_wb_reg_write, r_wb_rd);
  end

`ifdef HAZARD_LOAD_STALL_EN
  logic [CNT_W-1:0] r_stall_count;

  always_comb begin
    w_stall = id_valid & ~flush & r_ex_valid & r_ex_mem_read & (r_ex_rd != '0) &
              ((r_ex_rd == id_rs) | (r_ex_rd == id_rt));
  end

  always_ff @(posedge clk) begin
    if (!reset)
      r_stall_count <= '0;
    else if (w_stall && r_stall_count != {CNT_W{1'b1}})
      r_stall_count <= r_stall_count + CNT_W'(1);
  end

  assign stall_count = r_stall_count;
`else
  logic w_unused_ex_mem_read;

  assign w_unused_ex_mem_read = r_ex_mem_read;
  assign w_stall              = 1'b0;
  assign stall_count          = '0;
`endif

  assign stall = w_stall;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Scoreboard bench for forward_hazard_unit: directed hazard scenarios then randomized traffic,
// checked against a history-based reference model (honours HAZARD_LOAD_STALL_EN).
module tb_forward_hazard_unit;
  localparam int AW = 5;
  localparam int CW = 3;
`ifdef HAZARD_LOAD_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          id_reg_write, id_mem_read, flush;
  logic [1:0]    forward_a, forward_b;
  logic          stall;
  logic [CW-1:0] stall_count;

  forward_hazard_unit #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .forward_a(forward_a), .forward_b(forward_b),
    .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] rs, rt, rd;
    logic          rw, mr;
  } instr_t;

  typedef struct {
    bit            chk;
    logic [1:0]    fa, fb;
    logic          st;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t   sb[$];
  // hist[0] is the instruction in EX, hist[1] one cycle older, hist[2] two cycles older.
  instr_t hist[3];
  int     m_cnt;
  int     n_tests = 0;
  int     n_fail  = 0;
  bit     done    = 1'b0;

  function automatic logic [1:0] ref_fwd(input logic [AW-1:0] src);
    if (!hist[0].v || src == 0) return 2'b00;
    for (int d = 1; d <= 2; d++)
      if (hist[d].v && hist[d].rw && hist[d].rd != 0 && hist[d].rd == src)
        return (d == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic issue(input bit v, input int rs, input int rt, input int rd,
                       input bit rw, input bit mr, input bit fl, input bit rst_n,
                       input bit chk);
    exp_t   e;
    instr_t n;
    bit     st;
    @(negedge clk);
    reset = rst_n; id_valid = v; flush = fl;
    id_rs = AW'(rs); id_rt = AW'(rt); id_rd = AW'(rd);
    id_reg_write = rw; id_mem_read = mr;
    st = STALL_EN && v && !fl && hist[0].v && hist[0].mr && hist[0].rd != 0 &&
         (hist[0].rd == id_rs || hist[0].rd == id_rt);
    e.chk = chk;
    e.fa  = ref_fwd(hist[0].rs);
    e.fb  = ref_fwd(hist[0].rt);
    e.st  = st;
    e.cnt = CW'(m_cnt);
    sb.push_back(e);
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) hist[i] = '0;
      m_cnt = 0;
    end else begin
      n.v  = v && !st && !fl;
      n.rs = id_rs; n.rt = id_rt; n.rd = id_rd;
      n.rw = n.v && rw;
      n.mr = n.v && mr;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = n;
      if (st && m_cnt < (1 << CW) - 1) m_cnt++;
    end
  endtask

  task automatic nop();
    issue(0, 0, 0, 0, 0, 0, 0, 1, 1);
  endtask

  // Monitor: one expected entry per cycle, compared mid-low-phase after inputs settle.
  initial begin : monitor
    exp_t e;
    int   cyc = 0;
    while (!(done && sb.size() == 0)) begin
      @(negedge clk);
      #2;
      cyc++;
      if (cyc > 20000) begin
        $display("FAIL timeout: monitor cycle budget exhausted, queue=%0d", sb.size());
        n_tests++; n_fail++;
        break;
      end
      if (sb.size() == 0) continue;
      e = sb.pop_front();
      if (!e.chk) continue;
      n_tests++;
      if (forward_a !== e.fa) begin
        n_fail++;
        $display("FAIL forward_a t=%0t got=%b exp=%b", $time, forward_a, e.fa);
      end
      n_tests++;
      if (forward_b !== e.fb) begin
        n_fail++;
        $display("FAIL forward_b t=%0t got=%b exp=%b", $time, forward_b, e.fb);
      end
      n_tests++;
      if (stall !== e.st) begin
        n_fail++;
        $display("FAIL stall t=%0t got=%b exp=%b", $time, stall, e.st);
      end
      n_tests++;
      if (stall_count !== e.cnt) begin
        n_fail++;
        $display("FAIL stall_count t=%0t got=%0d exp=%0d", $time, stall_count, e.cnt);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : driver
    for (int i = 0; i < 3; i++) hist[i] = '0;
    m_cnt = 0;
    reset = 1'b0; id_valid = 1'b0; flush = 1'b0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    // First cycle precedes any reset edge: state is unknown, so it is not checked.
    issue(1, 1, 2, 3, 1, 1, 0, 0, 0);
    issue(1, 1, 2, 3, 1, 1, 0, 0, 1);
    nop(); nop();
    // add r3 ; sub r?, r3, r1
    issue(1, 1, 2, 3, 1, 0, 0, 1, 1);
    issue(1, 3, 1, 6, 1, 0, 0, 1, 1);
    nop(); nop(); nop();
    // writer r4 ; unrelated ; reader r4 as rt, then writers of r4 in MEM and WB
    issue(1, 1, 2, 4, 1, 0, 0, 1, 1);
    issue(1, 6, 7, 8, 1, 0, 0, 1, 1);
    issue(1, 9, 4, 10, 1, 0, 0, 1, 1);
    nop(); nop();
    issue(1, 1, 2, 4, 1, 0, 0, 1, 1);
    issue(1, 1, 2, 4, 1, 0, 0, 1, 1);
    issue(1, 9, 4, 10, 1, 0, 0, 1, 1);
    nop(); nop(); nop();
    // lw r5 ; add using r5 (held in ID while stalled)
    issue(1, 1, 0, 5, 1, 1, 0, 1, 1);
    issue(1, 5, 2, 6, 1, 0, 0, 1, 1);
    issue(1, 5, 2, 6, 1, 0, 0, 1, 1);
    nop(); nop(); nop();
    // writer r0 ; reader r0 ; load r0 ; reader r0
    issue(1, 1, 2, 0, 1, 0, 0, 1, 1);
    issue(1, 0, 0, 7, 1, 0, 0, 1, 1);
    issue(1, 1, 2, 0, 1, 1, 0, 1, 1);
    issue(1, 0, 0, 7, 1, 0, 0, 1, 1);
    nop(); nop(); nop();
    // load-use coinciding with flush
    issue(1, 1, 0, 5, 1, 1, 0, 1, 1);
    issue(1, 5, 5, 6, 1, 0, 1, 1, 1);
    nop(); nop(); nop();
    // repeated load-use to drive the narrow counter into saturation
    for (int k = 0; k < 6; k++) begin
      issue(1, 1, 0, 5, 1, 1, 0, 1, 1);
      issue(1, 2, 5, 6, 1, 0, 0, 1, 1);
      issue(1, 2, 5, 6, 1, 0, 0, 1, 1);
    end
    // reset mid-stall, then reset held
    issue(1, 1, 0, 5, 1, 1, 0, 1, 1);
    issue(1, 5, 2, 6, 1, 0, 0, 0, 1);
    issue(1, 5, 2, 6, 1, 0, 0, 0, 1);
    nop(); nop();
    for (int k = 0; k < 2000; k++) begin
      issue(($urandom_range(0, 99) < 85),
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 35),
            ($urandom_range(0, 99) < 8), !($urandom_range(0, 199) < 2), 1);
    end
    nop();
    done = 1'b1;
  end
endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 Parameter: ADDR_W, default 5, register-address width.
REQ-002 Parameter: CNT_W, default 16, stall-counter width.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset.
REQ-005 Port: id_valid  input  1  a real instruction is in ID.
REQ-006 Port: id_rs, id_rt  input  ADDR_W each  source registers of the ID instruction.
REQ-007 Port: id_rd  input  ADDR_W  destination register of the ID instruction.
REQ-008 Port: id_reg_write, id_mem_read  input  1 each  the ID instruction writes a register / is a load.
REQ-009 Port: flush  input  1  taken branch; kills the ID instruction.
REQ-010 Port: forward_a, forward_b  output  2 each  EX operand-select codes: 00 register file, 10 from MEM, 01 from WB.
REQ-011 Port: stall  output  1  hold PC and IF/ID; insert a bubble into EX.
REQ-012 Port: stall_count  output  CNT_W  saturating count of stall cycles.

Function
REQ-013 Shadow pipeline SHALL be held internally: EX {valid, rs, rt, rd, reg_write, mem_read}; MEM {valid, rd, reg_write}; WB {valid, rd, reg_write}.
REQ-014 Every edge: WB <= MEM; MEM <= EX; EX <= ID fields with valid = id_valid & ~stall & ~flush.
REQ-015 A bubble (EX valid = 0) SHALL force reg_write and mem_read to 0 in that slot.
REQ-016 forward_a SHALL be combinational from shadow state: 10 if MEM.valid & MEM.reg_write & MEM.rd != 0 & MEM.rd == EX.rs; else 01 if the same test holds for WB; else 00.
REQ-017 forward_b SHALL use the identical rule with EX.rt.
REQ-018 MEM SHALL have priority over WB when both match; forward_a and forward_b SHALL be independent and may both be non-zero.
REQ-019 With EX.valid = 0, forward_a and forward_b SHALL be 00.
REQ-020 Register 0 SHALL never be forwarded.
REQ-021 stall = id_valid & ~flush & EX.valid & EX.mem_read & EX.rd != 0 & (EX.rd == id_rs | EX.rd == id_rt), combinational.
REQ-022 A load-use hazard SHALL stall exactly one cycle; on the next cycle the load is in MEM and is forwarded with code 10.
REQ-023 flush SHALL override stall; flush and stall asserted together SHALL insert one bubble only.
REQ-024 stall_count SHALL increment on each edge where stall = 1 and saturate at all-ones with no wrap.

Reset
REQ-025 When reset = 0 at an edge, all shadow valid, reg_write and mem_read bits SHALL clear and stall_count SHALL clear to 0.
REQ-026 During and after reset, forward_a = 00, forward_b = 00 and stall = 0 until new instructions enter.
REQ-027 Reset mid-stall SHALL drop stall in the cycle after the reset edge and discard all in-flight shadow entries.

Configuration
REQ-028 Macro HAZARD_LOAD_STALL_EN defined: REQ-021 to REQ-024 are active.
REQ-029 Macro HAZARD_LOAD_STALL_EN undefined: stall is tied to 0, stall_count is tied to 0 and the counter logic is absent; forwarding behaviour is unchanged.

Verification
REQ-030 Scenario: add r3 then sub using r3 as rs, back-to-back -> forward_a = 10, forward_b = 00 in the sub's EX cycle.
REQ-031 Scenario: writer of r4, one unrelated instruction, then reader of r4 as rt -> forward_b = 01; with writers of r4 in both MEM and WB -> forward_b = 10.
REQ-032 Scenario: lw r5 then add reading r5 -> stall = 1 for exactly one cycle, stall_count goes 0 to 1, then forward_a = 10.
REQ-033 Scenario: writer of r0, then reader of r0 -> forward codes stay 00 and stall = 0.
REQ-034 Scenario: load-use hazard with flush = 1 in the same cycle -> stall = 0, one bubble in EX, stall_count unchanged.
REQ-035 Scenario: CNT_W = 2 with five consecutive stall cycles -> stall_count saturates at 3; reset = 0 -> stall_count = 0 and all outputs at reset values.
